mem_io_bridge: RTL and testbench

- Sits directly downstream of the CPU data port: takes MemWrite, ALUResult (address) and WriteData, and returns ReadData.
- Decodes each access to one of two regions:
  - the data RAM, passed through to an external RAM port;
  - a small MMIO register file.
- The MMIO block holds a TX byte FIFO, which drains to an external sink over valid/ready, plus a status register, a cycle counter and a done flag.
- Reads are combinational, as the single-cycle CPU requires. Writes commit on the rising clk edge.

---
 rtl/mem_io_bridge_pkg.sv | 30 +++
 rtl/mem_io_bridge_if.sv | 26 ++
 rtl/mem_io_bridge_tx_fifo.sv | 48 ++++
 rtl/mem_io_bridge.sv | 93 +++++++++
 tb/tb_mem_io_bridge.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_io_bridge_pkg.sv
// Shared definitions for the CPU data-port bridge: MMIO offsets, STATUS bit
// positions and the address-region decode.
package bridge_pkg;

  localparam logic [1:0] OFF_TX     = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CYCLES = 2'd2;
  localparam logic [1:0] OFF_CTRL   = 2'd3;

  localparam int unsigned ST_EMPTY  = 0;
  localparam int unsigned ST_FULL   = 1;
  localparam int unsigned ST_CNT_LO = 2;
  localparam int unsigned ST_OVF    = 8;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_MMIO,
    REG_NONE
  } region_t;

  // RAM is checked first so an overlapping MMIO window can never shadow RAM.
  function automatic region_t decode_region(input logic [31:0] addr,
                                            input logic [32:0] ram_bytes,
                                            input logic [31:0] mmio_base);
    if ({1'b0, addr} < ram_bytes)        return REG_RAM;
    if (addr[31:4] == mmio_base[31:4])   return REG_MMIO;
    return REG_NONE;
  endfunction

endpackage

// File: rtl/mem_io_bridge_if.sv
// CPU data port, external RAM port and TX byte stream of the bridge.
interface mem_io_bridge_if #(
  parameter int unsigned RAM_AW = 14
);
  logic              MemWrite;
  logic [31:0]       ALUResult;
  logic [31:0]       WriteData;
  logic [31:0]       ReadData;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              tx_ready;

  modport master (
    output MemWrite, ALUResult, WriteData, ram_rdata, tx_ready,
    input  ReadData, ram_we, ram_addr, ram_wdata, tx_valid, tx_data
  );

  modport slave (
    input  MemWrite, ALUResult, WriteData, ram_rdata, tx_ready,
    output ReadData, ram_we, ram_addr, ram_wdata, tx_valid, tx_data
  );
endinterface

// File: rtl/mem_io_bridge_tx_fifo.sv
// Byte FIFO for the TX stream; a push while full is still taken when a pop
// frees the head slot in the same cycle.
module tx_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] head, tail;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[head];

  always_ff @(posedge clk) begin
    if (do_push) mem[tail] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + PW'(1);
      if (do_pop)  head <= head + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/mem_io_bridge.sv
// Data-port bridge: decodes CPU loads/stores into the RAM region or the MMIO
// register file (TX FIFO, STATUS, CYCLES, CTRL); loads are combinational.
module mem_io_bridge
  import bridge_pkg::*;
#(
  parameter int unsigned RAM_AW     = 14,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] MMIO_BASE  = 32'h0001_0000,
  parameter logic [31:0] CYC_RST    = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  mem_io_bridge_if.slave  bus,
  output logic            done
);
  localparam logic [32:0] RAM_BYTES = 33'd4 << RAM_AW;
  localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1;

  region_t       region;
  logic [1:0]    off;
  logic          mmio_we, push_req, pop, ovf_set, ovf_clr;
  logic          fifo_full, fifo_empty, overflow;
  logic [CW-1:0] fifo_count;
  logic [31:0]   cnt_wide, status, cycles;
  logic [2:0]    cnt_sat;

  assign region   = decode_region(bus.ALUResult, RAM_BYTES, MMIO_BASE);
  assign off      = bus.ALUResult[3:2];
  assign mmio_we  = bus.MemWrite && (region == REG_MMIO);
  assign push_req = mmio_we && (off == OFF_TX);
  assign pop      = bus.tx_valid && bus.tx_ready;
  assign ovf_set  = push_req && fifo_full && !pop;
  assign ovf_clr  = mmio_we && (off == OFF_STATUS) && bus.WriteData[ST_OVF];

  assign bus.ram_we    = bus.MemWrite && (region == REG_RAM);
  assign bus.ram_addr  = bus.ALUResult[RAM_AW+1:2];
  assign bus.ram_wdata = bus.WriteData;
  assign bus.tx_valid  = !fifo_empty;

  tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .pop   (pop),
    .din   (bus.WriteData[7:0]),
    .dout  (bus.tx_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Count field is only three bits wide; deeper FIFOs report 7 when fuller.
  assign cnt_wide = 32'(fifo_count);
  assign cnt_sat  = (cnt_wide > 32'd7) ? 3'd7 : cnt_wide[2:0];

  always_comb begin
    status                   = '0;
    status[ST_EMPTY]         = fifo_empty;
    status[ST_FULL]          = fifo_full;
    status[ST_CNT_LO +: 3]   = cnt_sat;
    status[ST_OVF]           = overflow;
  end

  always_comb begin
    bus.ReadData = '0;
    case (region)
      REG_RAM:  bus.ReadData = bus.ram_rdata;
      REG_MMIO: begin
        case (off)
          OFF_STATUS: bus.ReadData = status;
          OFF_CYCLES: bus.ReadData = cycles;
          OFF_CTRL:   bus.ReadData = {31'b0, done};
          default:    bus.ReadData = '0;
        endcase
      end
      default:  bus.ReadData = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycles   <= CYC_RST;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (mmio_we && (off == OFF_CYCLES)) cycles <= '0;
      else                                cycles <= cycles + 32'd1;
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
      if (mmio_we && (off == OFF_CTRL)) done <= bus.WriteData[0];
    end
  end
endmodule

// File: tb/tb_mem_io_bridge.sv
// Bench for mem_io_bridge: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_io_bridge;
  localparam int unsigned D     = 4;
  localparam logic [31:0] CYC_W = 32'hFFFF_FFFD;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic done, done_w;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_io_bridge_if #(.RAM_AW(14)) bus_i ();
  mem_io_bridge_if #(.RAM_AW(14)) bus_w ();

  mem_io_bridge #(.RAM_AW(14), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .bus(bus_i.slave), .done(done)
  );

  mem_io_bridge #(.RAM_AW(14), .FIFO_DEPTH(D), .CYC_RST(CYC_W)) dut_wrap (
    .clk(clk), .reset(reset), .bus(bus_w.slave), .done(done_w)
  );

  // Reference state
  byte unsigned q[$];
  logic         ovf_m    = 1'b0;
  logic         done_m   = 1'b0;
  logic [31:0]  cyc_m    = '0;
  logic [31:0]  cyc_wm   = CYC_W;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic is_ram(input logic [31:0] a);
    return a < 32'h0001_0000;
  endfunction

  function automatic logic is_mmio(input logic [31:0] a);
    return !is_ram(a) && (a >= 32'h0001_0000) && (a < 32'h0001_0010);
  endfunction

  function automatic logic [31:0] exp_status();
    int unsigned n = q.size();
    int unsigned c = (n > 7) ? 7 : n;
    return 32'((n == 0) ? 1 : 0) + 32'((n == D) ? 2 : 0) + 32'(c * 4) + (ovf_m ? 32'h100 : 32'h0);
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] a, input logic [31:0] rdata);
    if (is_ram(a)) return rdata;
    if (!is_mmio(a)) return 32'h0;
    case ((a - 32'h0001_0000) / 4)
      1:       return exp_status();
      2:       return cyc_m;
      3:       return {31'b0, done_m};
      default: return 32'h0;
    endcase
  endfunction

  // Behavioural model: commits the cycle's access at each rising edge.
  always @(posedge clk or negedge reset) begin
    logic [31:0] a;
    logic        we, popm, preq, acc;
    int unsigned o;
    if (!reset) begin
      q.delete();
      ovf_m  = 1'b0;
      done_m = 1'b0;
      cyc_m  = '0;
      cyc_wm = CYC_W;
    end else begin
      a    = bus_i.ALUResult;
      we   = bus_i.MemWrite;
      o    = (a - 32'h0001_0000) / 4;
      popm = (q.size() != 0) && bus_i.tx_ready;
      preq = we && is_mmio(a) && (o == 0);
      acc  = preq && ((q.size() < D) || popm);
      if (popm) void'(q.pop_front());
      if (acc)  q.push_back(bus_i.WriteData[7:0]);
      if (preq && !acc) ovf_m = 1'b1;
      else if (we && is_mmio(a) && (o == 1) && bus_i.WriteData[8]) ovf_m = 1'b0;
      cyc_m = (we && is_mmio(a) && (o == 2)) ? 32'h0 : cyc_m + 32'd1;
      if (we && is_mmio(a) && (o == 3)) done_m = bus_i.WriteData[0];
      cyc_wm = cyc_wm + 32'd1;
    end
  end

  // Per-cycle comparison, mid-cycle.
  always @(negedge clk) begin
    chk("ReadData", bus_i.ReadData, exp_rd(bus_i.ALUResult, bus_i.ram_rdata));
    chk("ram_we", 32'(bus_i.ram_we), 32'(bus_i.MemWrite && is_ram(bus_i.ALUResult)));
    chk("ram_addr", 32'(bus_i.ram_addr), (bus_i.ALUResult / 4) % 32'h4000);
    chk("ram_wdata", bus_i.ram_wdata, bus_i.WriteData);
    chk("tx_valid", 32'(bus_i.tx_valid), 32'(q.size() != 0));
    if (q.size() != 0) chk("tx_data", 32'(bus_i.tx_data), 32'(q[0]));
    chk("done", 32'(done), 32'(done_m));
    chk("wrap_cycles", bus_w.ReadData, cyc_wm);
  end

  task automatic cyc(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic rdy);
    @(posedge clk);
    #1;
    bus_i.MemWrite  = we;
    bus_i.ALUResult = a;
    bus_i.WriteData = wd;
    bus_i.tx_ready  = rdy;
    bus_i.ram_rdata = $urandom;
    #2;
  endtask

  initial begin
    bus_i.MemWrite = 1'b0; bus_i.ALUResult = 32'h0001_0004; bus_i.WriteData = '0;
    bus_i.tx_ready = 1'b0; bus_i.ram_rdata = '0;
    bus_w.MemWrite = 1'b0; bus_w.ALUResult = 32'h0001_0008; bus_w.WriteData = '0;
    bus_w.tx_ready = 1'b0; bus_w.ram_rdata = '0;

    #2;
    chk("rst_tx_valid", 32'(bus_i.tx_valid), 32'h0);
    chk("rst_tx_data", 32'(bus_i.tx_data), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_status", bus_i.ReadData, 32'h1);
    @(posedge clk); #1 reset = 1'b1;

    // Counter from reset, and wrap on the preloaded instance
    for (int k = 1; k <= 10; k++) begin
      cyc(1'b0, (k == 10) ? 32'h0001_0008 : 32'h0000_0100, 32'h0, 1'b0);
      if (k == 2) chk("wrap_ffff", bus_w.ReadData, 32'hFFFF_FFFF);
      if (k == 3) chk("wrap_zero", bus_w.ReadData, 32'h0000_0000);
    end
    chk("cycles_10", bus_i.ReadData, 32'd10);

    // Decode basics
    cyc(1'b0, 32'h0001_0004, 32'h0, 1'b0);
    chk("status_idle", bus_i.ReadData, 32'h1);
    cyc(1'b1, 32'h0000_0010, 32'h1234_5678, 1'b0);
    chk("ram_we_st", 32'(bus_i.ram_we), 32'h1);
    chk("ram_addr_st", 32'(bus_i.ram_addr), 32'h4);
    chk("ram_wdata_st", bus_i.ram_wdata, 32'h1234_5678);
    cyc(1'b0, 32'h0001_0020, 32'h0, 1'b0);
    chk("unmapped_rd", bus_i.ReadData, 32'h0);

    // Fill, overflow, drain, clear overflow
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'h0001_0000, 32'h41 + 32'(i), 1'b0);
    cyc(1'b0, 32'h0001_0004, 32'h0, 1'b0);
    chk("status_full", bus_i.ReadData, 32'h12);
    cyc(1'b1, 32'h0001_0000, 32'h45, 1'b0);
    cyc(1'b0, 32'h0001_0004, 32'h0, 1'b0);
    chk("status_ovf", bus_i.ReadData, 32'h112);
    chk("head_kept", 32'(bus_i.tx_data), 32'h41);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 32'h0001_0004, 32'h0, 1'b1);
      chk("drain_valid", 32'(bus_i.tx_valid), 32'h1);
      chk("drain_data", 32'(bus_i.tx_data), 32'h41 + 32'(i));
    end
    cyc(1'b0, 32'h0001_0004, 32'h0, 1'b1);
    chk("drained", 32'(bus_i.tx_valid), 32'h0);
    cyc(1'b1, 32'h0001_0004, 32'h100, 1'b0);
    cyc(1'b0, 32'h0001_0004, 32'h0, 1'b0);
    chk("ovf_cleared", bus_i.ReadData, 32'h1);

    // Full FIFO with simultaneous pop and push
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'h0001_0000, 32'h51 + 32'(i), 1'b0);
    cyc(1'b1, 32'h0001_0000, 32'h55, 1'b1);
    cyc(1'b0, 32'h0001_0004, 32'h0, 1'b0);
    chk("full_push_pop", bus_i.ReadData, 32'h12);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 32'h0000_0000, 32'h0, 1'b1);
      chk("fpp_data", 32'(bus_i.tx_data), 32'h52 + 32'(i));
    end
    cyc(1'b0, 32'h0000_0000, 32'h0, 1'b1);
    chk("fpp_empty", 32'(bus_i.tx_valid), 32'h0);

    // Empty FIFO with push and ready together
    cyc(1'b1, 32'h0001_0000, 32'h7E, 1'b1);
    chk("empty_pp_valid", 32'(bus_i.tx_valid), 32'h0);
    cyc(1'b0, 32'h0001_0004, 32'h0, 1'b1);
    chk("empty_pp_next", 32'(bus_i.tx_valid), 32'h1);
    chk("empty_pp_data", 32'(bus_i.tx_data), 32'h7E);
    cyc(1'b0, 32'h0001_0004, 32'h0, 1'b0);
    chk("empty_pp_gone", 32'(bus_i.tx_valid), 32'h0);

    // Counter write wins over increment
    cyc(1'b1, 32'h0001_0008, 32'hDEAD_BEEF, 1'b0);
    cyc(1'b0, 32'h0001_0008, 32'h0, 1'b0);
    chk("cycles_clr", bus_i.ReadData, 32'h0);
    cyc(1'b0, 32'h0001_0008, 32'h0, 1'b0);
    chk("cycles_after", bus_i.ReadData, 32'h1);

    // done flag, then asynchronous reset with bytes queued
    cyc(1'b1, 32'h0001_000C, 32'h1, 1'b0);
    chk("done_pre", 32'(done), 32'h0);
    cyc(1'b0, 32'h0001_000C, 32'h0, 1'b0);
    chk("done_set", 32'(done), 32'h1);
    chk("ctrl_rd", bus_i.ReadData, 32'h1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h0001_0000, 32'h61 + 32'(i), 1'b0);
    cyc(1'b0, 32'h0001_0004, 32'h0, 1'b0);
    chk("queued3", bus_i.ReadData, 32'h0C);
    reset = 1'b0;
    #1;
    chk("arst_done", 32'(done), 32'h0);
    chk("arst_valid", 32'(bus_i.tx_valid), 32'h0);
    chk("arst_status", bus_i.ReadData, 32'h1);
    @(posedge clk); #1 reset = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      int unsigned r;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      case (r)
        0, 1:    a = $urandom & 32'h0000_FFFF;
        2, 3:    a = 32'h0001_0000 + 32'($urandom_range(0, 3));
        4, 5:    a = 32'h0001_0004 + 32'($urandom_range(0, 3));
        6:       a = 32'h0001_0008 + 32'($urandom_range(0, 3));
        7:       a = 32'h0001_000C + 32'($urandom_range(0, 3));
        8:       a = $urandom | 32'h8000_0000;
        default: a = 32'h0001_0010 + 32'($urandom_range(0, 63));
      endcase
      cyc(1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)));
    end

    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
